// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and default parameter values for the debounce_sync block.
//   deb_state_t           : stability-filter FSM state encoding
//   DEB_SYNC_STAGES_DEF   : default synchronizer depth
//   DEB_STABLE_CYCLES_DEF : default number of stable samples to accept a level
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEB_SYNC_STAGES_DEF   = 2;
    localparam int DEB_STABLE_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_t;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_chain
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEB_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
// Synchronizes a raw, possibly bouncing input and filters it so that a new
// level is accepted only after STABLE_CYCLES consecutive synchronized samples.
// Ports:
//   clk        : rising-edge system clock
//   rst        : asynchronous active-low reset
//   data_raw   : unsynchronized raw input
//   data_clean : debounced, synchronous level
//   rise       : one-cycle pulse when data_clean goes 0->1
//   fall       : one-cycle pulse when data_clean goes 1->0
//   busy       : high while a candidate level change is being qualified
// Build option:
//   DEBOUNCE_EDGE_EN : when defined, rise/fall pulse registers are built;
//                      otherwise rise and fall are tied to 0.
// -----------------------------------------------------------------------------
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic data_raw,
    output logic data_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             w_s;
    deb_state_t       r_state;
    deb_state_t       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_accept;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk (clk),
        .rst (rst),
        .d   (data_raw),
        .q   (w_s)
    );

    // Final qualifying sample: the candidate level is seen for the
    // STABLE_CYCLES-th consecutive time.
    assign w_accept = ((r_state == WAIT_HIGH) && w_s && (r_cnt == CNT_LAST)) ||
                      ((r_state == WAIT_LOW) && !w_s && (r_cnt == CNT_LAST));

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            IDLE_LOW: begin
                if (w_s) begin
                    w_state_d = WAIT_HIGH;
                    w_cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    w_state_d = IDLE_LOW;
                    w_cnt_d   = '0;
                end else if (w_accept) begin
                    w_state_d = IDLE_HIGH;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!w_s) begin
                    w_state_d = WAIT_LOW;
                    w_cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (w_s) begin
                    w_state_d = IDLE_HIGH;
                    w_cnt_d   = '0;
                end else if (w_accept) begin
                    w_state_d = IDLE_LOW;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_d = IDLE_LOW;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign data_clean = (r_state == IDLE_HIGH) || (r_state == WAIT_LOW);
    assign busy       = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);

`ifdef DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Registered alongside the state so the pulse lines up with data_clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept && (r_state == WAIT_HIGH);
            r_fall <= w_accept && (r_state == WAIT_LOW);
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
// Directed bench for debounce_sync (SYNC_STAGES=2, STABLE_CYCLES=8).
// Expected output changes are queued with the edge number at which they must
// appear; an independent monitor compares every observed output change.
// With a raw change captured at edge k: busy rises after k+2, data_clean
// changes (and busy drops) after k+9; with DEBOUNCE_EDGE_EN the pulse
// drops again after k+10.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic data_raw = 1'b0;
    logic data_clean;
    logic rise;
    logic fall;
    logic busy;

    debounce_sync #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_raw   (data_raw),
        .data_clean (data_clean),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  val;   // {data_clean, rise, fall, busy}
    } ev_t;

    ev_t        exp_q[$];
    int         n_vec    = 0;
    int         n_miss   = 0;
    logic [3:0] prev_out = 4'b0000;
    logic [3:0] cur_out;
    ev_t        mon_ev;

    task automatic push(input int unsigned cyc, input logic [3:0] val);
        ev_t e;
        e.cyc = cyc;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Events for one clean qualification of level lvl captured at edge k.
    task automatic expect_accept(input int unsigned k, input logic lvl);
        push(k + 2, {~lvl, 1'b0, 1'b0, 1'b1});
`ifdef DEBOUNCE_EDGE_EN
        push(k + 9, {lvl, lvl, ~lvl, 1'b0});
        push(k + 10, {lvl, 3'b000});
`else
        push(k + 9, {lvl, 3'b000});
`endif
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string name, input logic [3:0] exp_val);
        n_vec++;
        if ({data_clean, rise, fall, busy} !== exp_val) begin
            n_miss++;
            $display("FAIL %s: clean/rise/fall/busy=%b, required %b", name,
                     {data_clean, rise, fall, busy}, exp_val);
        end
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL %s_drained: %0d expected events still pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every change of the output vector must match the next queued event.
    always @(negedge clk) begin
        cur_out = {data_clean, rise, fall, busy};
        if (cur_out !== prev_out) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_event: edge=%0d clean/rise/fall/busy=%b, required no change",
                         edge_no, cur_out);
            end else begin
                mon_ev = exp_q.pop_front();
                if (mon_ev.cyc != edge_no || mon_ev.val !== cur_out) begin
                    n_miss++;
                    $display("FAIL event: edge=%0d clean/rise/fall/busy=%b, required edge=%0d value=%b",
                             edge_no, cur_out, mon_ev.cyc, mon_ev.val);
                end
            end
        end
        prev_out = cur_out;
    end

    initial begin
        int unsigned k;

        #1;
        check_out("reset_state", 4'b0000);
        edges(2);
        rst = 1'b1;
        edges(2);

        // Clean step 0->1.
        k = edge_no + 1;
        expect_accept(k, 1'b1);
        data_raw = 1'b1;
        edges(12);
        check_drained("clean_step");
        check_out("clean_step_level", 4'b1000);

        // Round trip: hold high, then drop to 0.
        edges(20);
        k = edge_no + 1;
        expect_accept(k, 1'b0);
        data_raw = 1'b0;
        edges(12);
        check_drained("round_trip_fall");
        check_out("round_trip_level", 4'b0000);

        // Bounce: 3 high / 3 low, five times, then hold high.
        k = edge_no + 1;
        for (int i = 0; i < 5; i++) begin
            push(k + 6 * i + 2, 4'b0001);
            push(k + 6 * i + 5, 4'b0000);
        end
        expect_accept(k + 30, 1'b1);
        for (int i = 0; i < 5; i++) begin
            data_raw = 1'b1;
            edges(3);
            data_raw = 1'b0;
            edges(3);
        end
        data_raw = 1'b1;
        edges(12);
        check_drained("bounce");
        check_out("bounce_level", 4'b1000);

        // Short glitch low for 5 clocks while clean is high.
        k = edge_no + 1;
        push(k + 2, 4'b1001);
        push(k + 7, 4'b1000);
        data_raw = 1'b0;
        edges(5);
        data_raw = 1'b1;
        edges(12);
        check_drained("glitch");
        check_out("glitch_level", 4'b1000);

        // Return to low before the reset scenario.
        k = edge_no + 1;
        expect_accept(k, 1'b0);
        data_raw = 1'b0;
        edges(12);
        check_drained("second_fall");

        // Reset while WAIT_HIGH holds cnt=5, then full requalification.
        k = edge_no + 1;
        push(k + 2, 4'b0001);
        data_raw = 1'b1;
        edges(7);
        push(edge_no + 1, 4'b0000);
        #2;
        rst = 1'b0;
        #1;
        check_out("reset_mid_wait", 4'b0000);
        @(negedge clk);
        k = edge_no + 1;
        expect_accept(k, 1'b1);
        rst = 1'b1;
        edges(12);
        check_drained("after_reset");
        check_out("after_reset_level", 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
